// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline hazard detection, forwarding and multi-cycle EX stall control
module hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  MemtoRegM,
  input  logic                  BranchD,
  input  logic                  PCSrcD,
  input  logic                  MultiCycleE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic                  Busy,
  output logic [CNT_W-1:0]      StallCount
);

  localparam logic       IDLE     = 1'b0;
  localparam logic       BUSY     = 1'b1;
  localparam logic [7:0] CNT_INIT = 8'(MD_LATENCY - 2);

  logic       state;
  logic [7:0] cnt;
  logic       effState;
  logic       lwStall;
  logic       brStall;
  logic       mdStall;
  logic       anyStall;

  // Register 0 is hardwired, so a zero specifier never creates a dependency
  function automatic logic depends(input logic en,
                                   input logic [REG_ADDR_W-1:0] dst,
                                   input logic [REG_ADDR_W-1:0] src);
    return en && (dst != '0) && (dst == src);
  endfunction

  // EX operand bypass: the younger result in MEM wins over the one in WB
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (depends(RegWriteM, WriteRegM, RsE))      ForwardAE = 2'b10;
    else if (depends(RegWriteW, WriteRegW, RsE)) ForwardAE = 2'b01;
    if (depends(RegWriteM, WriteRegM, RtE))      ForwardBE = 2'b10;
    else if (depends(RegWriteW, WriteRegW, RtE)) ForwardBE = 2'b01;
    ForwardAD = depends(RegWriteM, WriteRegM, RsD);
    ForwardBD = depends(RegWriteM, WriteRegM, RtD);
  end

  // Stall and flush decisions; a reset cycle evaluates the multi-cycle unit as idle
  always_comb begin
    effState = reset ? IDLE : state;
    lwStall  = depends(MemtoRegE, RtE, RsD) || depends(MemtoRegE, RtE, RtD);
    brStall  = BranchD && (depends(RegWriteE, WriteRegE, RsD) || depends(RegWriteE, WriteRegE, RtD) ||
                           depends(MemtoRegM, WriteRegM, RsD) || depends(MemtoRegM, WriteRegM, RtD));
    mdStall  = MultiCycleE && ((effState == IDLE) || (cnt != 8'd0));
    anyStall = lwStall || brStall || mdStall;
    StallF   = anyStall;
    StallD   = anyStall;
    StallE   = mdStall;
    // Holding EX for a multi-cycle op must not also bubble it away
    FlushE   = (lwStall || brStall) && !mdStall;
    FlushD   = PCSrcD && !anyStall;
  end

  // Multi-cycle sequencer: count down the remaining stall cycles, then release for one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else if (state == IDLE) begin
      if (MultiCycleE) begin
        state <= BUSY;
        cnt   <= CNT_INIT;
      end
    end else begin
      if (!MultiCycleE) begin
        state <= IDLE;
        cnt   <= 8'd0;
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign Busy = (state == BUSY);

  // Saturating count of cycles in which fetch was held
  always_ff @(posedge clock) begin
    if (reset) begin
      StallCount <= '0;
    end else if (anyStall && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, MultiCycleE;

  logic        StallF, StallD, StallE, FlushD, FlushE, ForwardAD, ForwardBD, Busy;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount;

  logic        StallF2, StallD2, StallE2, FlushD2, FlushE2, ForwardAD2, ForwardBD2, Busy2;
  logic [1:0]  ForwardAE2, ForwardBE2;
  logic [3:0]  StallCount2;

  hazard_controller #(.REG_ADDR_W(5), .MD_LATENCY(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
    .MultiCycleE(MultiCycleE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .Busy(Busy), .StallCount(StallCount)
  );

  hazard_controller #(.REG_ADDR_W(5), .MD_LATENCY(2), .CNT_W(4)) dut2 (
    .clock(clock), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
    .MultiCycleE(MultiCycleE), .StallF(StallF2), .StallD(StallD2), .StallE(StallE2),
    .FlushD(FlushD2), .FlushE(FlushE2), .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2),
    .ForwardAD(ForwardAD2), .ForwardBD(ForwardBD2), .Busy(Busy2), .StallCount(StallCount2)
  );

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, mrE, mrM, brD, pcD;
    logic [1:0] fAE, fBE;
    logic       fAD, fBD, stl, flE, flD;
  } vec_t;

  int total = 0;
  int bad   = 0;
  // Reference state: cycles the current op has spent in EX, and stall tallies
  int age1 = 0, age2 = 0, sc1 = 0, sc2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic hit(input logic en, input logic [4:0] a, input logic [4:0] b);
    return en && (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwdE(input logic [4:0] s);
    if (hit(RegWriteM, s, WriteRegM)) return 2'd2;
    if (hit(RegWriteW, s, WriteRegW)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic hazLw();
    return hit(MemtoRegE, RtE, RsD) || hit(MemtoRegE, RtE, RtD);
  endfunction

  function automatic logic hazBr();
    return BranchD && (hit(RegWriteE, WriteRegE, RsD) || hit(RegWriteE, WriteRegE, RtD) ||
                       hit(MemtoRegM, WriteRegM, RsD) || hit(MemtoRegM, WriteRegM, RtD));
  endfunction

  // An op stalls until it has spent lat-1 cycles in EX; reset restarts it
  function automatic logic mdExp(input int lat, input int age);
    return MultiCycleE && (reset || (age < lat - 1));
  endfunction

  task automatic clearAll();
    reset = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; PCSrcD = 0; MultiCycleE = 0;
  endtask

  task automatic cycle();
    logic lw, br, md1, md2, st1, st2;
    @(negedge clock);
    lw  = hazLw();
    br  = hazBr();
    md1 = mdExp(4, age1);
    md2 = mdExp(2, age2);
    st1 = lw | br | md1;
    st2 = lw | br | md2;
    chk("ForwardAE", ForwardAE, fwdE(RsE));
    chk("ForwardBE", ForwardBE, fwdE(RtE));
    chk("ForwardAD", ForwardAD, hit(RegWriteM, RsD, WriteRegM));
    chk("ForwardBD", ForwardBD, hit(RegWriteM, RtD, WriteRegM));
    chk("StallF", StallF, st1);
    chk("StallD", StallD, st1);
    chk("StallE", StallE, md1);
    chk("FlushE", FlushE, (lw | br) & ~md1);
    chk("FlushD", FlushD, PCSrcD & ~st1);
    chk("Busy", Busy, age1 != 0);
    chk("StallCount", StallCount, sc1);
    chk("StallF2", StallF2, st2);
    chk("StallE2", StallE2, md2);
    chk("FlushE2", FlushE2, (lw | br) & ~md2);
    chk("FlushD2", FlushD2, PCSrcD & ~st2);
    chk("Busy2", Busy2, age2 != 0);
    chk("StallCount2", StallCount2, sc2);
    @(posedge clock);
    if (reset) begin
      age1 = 0; age2 = 0; sc1 = 0; sc2 = 0;
    end else begin
      if (st1 && sc1 < 65535) sc1++;
      if (st2 && sc2 < 15) sc2++;
      age1 = MultiCycleE ? ((age1 == 3) ? 0 : age1 + 1) : 0;
      age2 = MultiCycleE ? ((age2 == 1) ? 0 : age2 + 1) : 0;
    end
    #1;
  endtask

  task automatic rstCycle();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  vec_t vecs[12];
  logic [4:0] seExp;
  logic [4:0] bzExp;

  initial begin
    vecs[0]  = '{1, 2, 8, 3, 0, 8, 8,   0, 1, 1, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 2, 5, 6, 0, 7, 6,   0, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 2, 4, 4, 0, 4, 4,   0, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{10, 10, 1, 2, 0, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[5]  = '{9, 3, 1, 9, 0, 0, 0,   0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0};
    vecs[6]  = '{0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{3, 12, 1, 2, 12, 0, 0, 1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 1, 0};
    vecs[8]  = '{13, 4, 1, 2, 0, 13, 0, 0, 1, 0, 0, 1, 1, 0,  0, 0, 1, 0, 1, 1, 0};
    vecs[9]  = '{3, 4, 1, 2, 7, 3, 0,   1, 1, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, 0, 1};
    vecs[10] = '{3, 4, 1, 2, 3, 0, 0,   0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{2, 5, 1, 5, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0};

    clearAll();
    reset = 1;
    @(posedge clock);
    #1;
    rstCycle();
    chk("rst_Busy", Busy, 0);
    chk("rst_StallCount", StallCount, 0);

    for (int i = 0; i < 12; i++) begin
      RsD = vecs[i].rsD; RtD = vecs[i].rtD; RsE = vecs[i].rsE; RtE = vecs[i].rtE;
      WriteRegE = vecs[i].wrE; WriteRegM = vecs[i].wrM; WriteRegW = vecs[i].wrW;
      RegWriteE = vecs[i].rwE; RegWriteM = vecs[i].rwM; RegWriteW = vecs[i].rwW;
      MemtoRegE = vecs[i].mrE; MemtoRegM = vecs[i].mrM;
      BranchD = vecs[i].brD; PCSrcD = vecs[i].pcD; MultiCycleE = 0;
      #1;
      chk($sformatf("v%0d_ForwardAE", i), ForwardAE, vecs[i].fAE);
      chk($sformatf("v%0d_ForwardBE", i), ForwardBE, vecs[i].fBE);
      chk($sformatf("v%0d_ForwardAD", i), ForwardAD, vecs[i].fAD);
      chk($sformatf("v%0d_ForwardBD", i), ForwardBD, vecs[i].fBD);
      chk($sformatf("v%0d_StallF", i), StallF, vecs[i].stl);
      chk($sformatf("v%0d_FlushE", i), FlushE, vecs[i].flE);
      chk($sformatf("v%0d_FlushD", i), FlushD, vecs[i].flD);
      cycle();
    end

    // Single load-use stall bumps the statistics counter once
    clearAll();
    rstCycle();
    MemtoRegE = 1; RtE = 9; RsD = 9;
    #1;
    chk("lu_StallF", StallF, 1);
    chk("lu_StallD", StallD, 1);
    chk("lu_FlushE", FlushE, 1);
    chk("lu_count0", StallCount, 0);
    cycle();
    clearAll();
    #1;
    chk("lu_StallF_after", StallF, 0);
    chk("lu_count1", StallCount, 1);
    cycle();

    // Held multi-cycle op, then squash while busy
    rstCycle();
    seExp = 5'b10111;
    bzExp = 5'b01110;
    for (int i = 0; i < 5; i++) begin
      MultiCycleE = 1;
      #1;
      chk($sformatf("md%0d_StallE", i), StallE, seExp[i]);
      chk($sformatf("md%0d_Busy", i), Busy, bzExp[i]);
      cycle();
    end
    MultiCycleE = 0;
    #1;
    chk("sq_Busy_pre", Busy, 1);
    chk("sq_StallE", StallE, 0);
    cycle();
    chk("sq_Busy", Busy, 0);

    // Multi-cycle op coinciding with load-use, then reset mid-op
    rstCycle();
    MultiCycleE = 1; MemtoRegE = 1; RtE = 9; RsD = 9;
    #1;
    chk("mix_StallF", StallF, 1);
    chk("mix_FlushE", FlushE, 0);
    chk("mix_StallE", StallE, 1);
    cycle();
    MemtoRegE = 0;
    #1;
    chk("mix_Busy", Busy, 1);
    cycle();
    reset = 1;
    #1;
    chk("rb_StallE_in_reset", StallE, 1);
    cycle();
    reset = 0;
    #1;
    chk("rb_Busy", Busy, 0);
    chk("rb_StallCount", StallCount, 0);
    chk("rb_StallE_mc1", StallE, 1);
    MultiCycleE = 0;
    #1;
    chk("rb_StallE_mc0", StallE, 0);
    cycle();

    // Counter saturation on the narrow instance
    clearAll();
    rstCycle();
    MemtoRegE = 1; RtE = 9; RsD = 9;
    repeat (20) cycle();
    chk("sat_StallCount2", StallCount2, 15);
    chk("sat_StallCount", StallCount, 20);
    clearAll();

    // Randomized traffic against the reference model
    repeat (400) begin
      reset       = ($urandom_range(0, 49) == 0);
      RsD         = 5'($urandom_range(0, 3));
      RtD         = 5'($urandom_range(0, 3));
      RsE         = 5'($urandom_range(0, 3));
      RtE         = 5'($urandom_range(0, 3));
      WriteRegE   = 5'($urandom_range(0, 3));
      WriteRegM   = 5'($urandom_range(0, 3));
      WriteRegW   = 5'($urandom_range(0, 3));
      RegWriteE   = 1'($urandom_range(0, 1));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      MemtoRegE   = 1'($urandom_range(0, 1));
      MemtoRegM   = 1'($urandom_range(0, 1));
      BranchD     = 1'($urandom_range(0, 1));
      PCSrcD      = 1'($urandom_range(0, 1));
      MultiCycleE = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
